l2_snoop_responder: RTL and testbench



---
 rtl/l2_pkg.sv | 34 +++
 rtl/snoop_mesi_next.sv | 59 +++++
 rtl/l2_snoop_responder.sv | 139 +++++++++++++
 tb/tb_l2_snoop_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - shared encodings for the L2 snoop responder
// Contents: MESI state, snoop op and snoop result encodings, way-width helper.
package l2_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_RFO   = 2'b10,
        OP_INVAL = 2'b11
    } snp_op_t;

    typedef enum logic [1:0] {
        RES_NOHIT = 2'b00,
        RES_HIT   = 2'b01,
        RES_HITM  = 2'b10
    } snp_res_t;

    localparam int L2_WAYS = 8;

    // A direct-mapped array still needs a one-bit way field.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    localparam int L2_WAY_W = way_w(L2_WAYS);

endpackage

// File: rtl/snoop_mesi_next.sv
// rtl/snoop_mesi_next.sv - combinational MESI downgrade for one snooped line
// Ports: op, cur_state in; new_state, res, need_wb, need_upd, err out.
// cur_state == MESI_I means the snoop missed: NOHIT and no side effects.
module snoop_mesi_next
    import l2_pkg::*;
(
    input  snp_op_t  op,
    input  mesi_t    cur_state,
    output mesi_t    new_state,
    output snp_res_t res,
    output logic     need_wb,
    output logic     need_upd,
    output logic     err
);

    always_comb begin
        new_state = cur_state;
        res       = RES_NOHIT;
        need_wb   = 1'b0;
        need_upd  = 1'b0;
        err       = 1'b0;
        if (cur_state != MESI_I) begin
            case (op)
                OP_READ: begin
                    new_state = MESI_S;
                    res       = (cur_state == MESI_M) ? RES_HITM : RES_HIT;
                    need_wb   = (cur_state == MESI_M);
                    need_upd  = (cur_state != MESI_S);
                end
                OP_RFO: begin
                    new_state = MESI_I;
                    res       = (cur_state == MESI_M) ? RES_HITM : RES_HIT;
                    need_wb   = (cur_state == MESI_M);
                    need_upd  = 1'b1;
                end
                OP_INVAL: begin
                    // Invalidating a dirty line would lose data, so it is
                    // flagged and then handled exactly like an RFO.
                    new_state = MESI_I;
                    need_upd  = 1'b1;
                    if (cur_state == MESI_M) begin
                        err     = 1'b1;
                        res     = RES_HITM;
                        need_wb = 1'b1;
                    end else begin
                        res     = RES_HIT;
                    end
                end
                default: begin
                    // A foreign WRITE to a line we hold means coherence broke;
                    // report it but leave the array untouched.
                    err = 1'b1;
                    res = RES_HIT;
                end
            endcase
        end
    end

endmodule

// File: rtl/l2_snoop_responder.sv
// rtl/l2_snoop_responder.sv - bus-side snoop responder for the split L2
// Ports: snp_* snoop request, tl_* tag/state lookup, su_* state update,
//        wb_* Modified-line writeback, res_valid/res result, proto_err flag.
module l2_snoop_responder
    import l2_pkg::*;
#(
    parameter  int ADDR_W   = 32,
    parameter  int OFFSET_W = 6,
    parameter  int INDEX_W  = 14,
    parameter  int WAYS     = L2_WAYS,
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
    localparam int WAY_W    = way_w(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  snp_valid,
    output logic                  snp_ready,
    input  logic [1:0]            snp_op,
    input  logic [ADDR_W-1:0]     snp_addr,
    output logic                  tl_req,
    output logic [INDEX_W-1:0]    tl_index,
    input  logic [WAYS*TAG_W-1:0] tl_tag,
    input  logic [WAYS*2-1:0]     tl_state,
    output logic                  su_we,
    output logic [INDEX_W-1:0]    su_index,
    output logic [WAY_W-1:0]      su_way,
    output logic [1:0]            su_state,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [ADDR_W-1:0]     wb_addr,
    output logic                  res_valid,
    output logic [1:0]            res,
    output logic                  proto_err
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOOKUP  = 3'd1;
    localparam logic [2:0] ST_COMPARE = 3'd2;
    localparam logic [2:0] ST_WB      = 3'd3;
    localparam logic [2:0] ST_UPDATE  = 3'd4;

    logic [2:0]               state, state_d;
    snp_op_t                  op_q;
    logic [ADDR_W-OFFSET_W-1:0] line_q;
    logic [INDEX_W-1:0]       idx_q;
    logic [TAG_W-1:0]         tag_q;

    logic                     hit;
    logic [WAY_W-1:0]         hit_way;
    mesi_t                    hit_state;
    mesi_t                    new_state_c;
    snp_res_t                 res_c;
    logic                     need_wb_c, need_upd_c, err_c;

    // Offset bits never matter: lookups and writebacks are per line.
    logic                     unused_offset;
    assign unused_offset = ^snp_addr[OFFSET_W-1:0];

    assign idx_q = line_q[INDEX_W-1:0];
    assign tag_q = line_q[ADDR_W-OFFSET_W-1:INDEX_W];

    // Scan from the top way down so the lowest-numbered match is kept.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        hit_state = MESI_I;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (tl_state[2*w +: 2] != 2'(MESI_I) && tl_tag[w*TAG_W +: TAG_W] == tag_q) begin
                hit       = 1'b1;
                hit_way   = WAY_W'(w);
                hit_state = mesi_t'(tl_state[2*w +: 2]);
            end
        end
    end

    snoop_mesi_next u_mesi_next (
        .op        (op_q),
        .cur_state (hit ? hit_state : MESI_I),
        .new_state (new_state_c),
        .res       (res_c),
        .need_wb   (need_wb_c),
        .need_upd  (need_upd_c),
        .err       (err_c)
    );

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:    if (snp_valid) state_d = ST_LOOKUP;
            ST_LOOKUP:  state_d = ST_COMPARE;
            ST_COMPARE: begin
                if (need_wb_c)       state_d = ST_WB;
                else if (need_upd_c) state_d = ST_UPDATE;
                else                 state_d = ST_IDLE;
            end
            ST_WB:      if (wb_ready) state_d = ST_UPDATE;
            ST_UPDATE:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_q     <= OP_READ;
            line_q   <= '0;
            su_index <= '0;
            su_way   <= '0;
            su_state <= 2'b00;
            wb_addr  <= '0;
        end else begin
            state <= state_d;
            if (state == ST_IDLE && snp_valid) begin
                op_q   <= snp_op_t'(snp_op);
                line_q <= snp_addr[ADDR_W-1:OFFSET_W];
            end
            // Captured once at COMPARE so su_* stay stable through WB and UPDATE.
            if (state == ST_COMPARE && need_upd_c) begin
                su_index <= idx_q;
                su_way   <= hit_way;
                su_state <= new_state_c;
            end
            if (state == ST_COMPARE && need_wb_c) begin
                wb_addr <= {line_q, {OFFSET_W{1'b0}}};
            end
        end
    end

    assign snp_ready = (state == ST_IDLE);
    assign tl_req    = (state == ST_LOOKUP);
    assign tl_index  = idx_q;
    assign wb_valid  = (state == ST_WB);
    assign su_we     = (state == ST_UPDATE);
    // Tag data only arrives in COMPARE, so the result is qualified there.
    assign res_valid = (state == ST_COMPARE);
    assign res       = res_valid ? res_c : RES_NOHIT;
    assign proto_err = res_valid & err_c;

endmodule

// File: tb/tb_l2_snoop_responder.sv
// tb/tb_l2_snoop_responder.sv - self-checking bench for l2_snoop_responder
module tb_l2_snoop_responder;

    localparam int ADDR_W = 32, OFFSET_W = 6, INDEX_W = 14, WAYS = 8;
    localparam int TAG_W = 12, WAY_W = 3;

    localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11;
    localparam logic [1:0] READ = 2'b00, WRITE = 2'b01, RFO = 2'b10, INVAL = 2'b11;
    localparam logic [1:0] NOHIT = 2'b00, HIT = 2'b01, HITM = 2'b10;

    logic                  clk, rst_n;
    logic                  snp_valid, snp_ready;
    logic [1:0]            snp_op;
    logic [ADDR_W-1:0]     snp_addr;
    logic                  tl_req;
    logic [INDEX_W-1:0]    tl_index;
    logic [WAYS*TAG_W-1:0] tl_tag;
    logic [WAYS*2-1:0]     tl_state;
    logic                  su_we;
    logic [INDEX_W-1:0]    su_index;
    logic [WAY_W-1:0]      su_way;
    logic [1:0]            su_state;
    logic                  wb_valid, wb_ready;
    logic [ADDR_W-1:0]     wb_addr;
    logic                  res_valid;
    logic [1:0]            res;
    logic                  proto_err;

    l2_snoop_responder #(
        .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .WAYS(WAYS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
        .tl_req(tl_req), .tl_index(tl_index), .tl_tag(tl_tag), .tl_state(tl_state),
        .su_we(su_we), .su_index(su_index), .su_way(su_way), .su_state(su_state),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .res_valid(res_valid), .res(res), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [TAG_W-1:0] tag_mem [WAYS];
    logic [1:0]       st_mem  [WAYS];

    always_comb begin
        tl_tag   = '0;
        tl_state = '0;
        for (int w = 0; w < WAYS; w++) begin
            tl_tag[w*TAG_W +: TAG_W] = tag_mem[w];
            tl_state[2*w +: 2]       = st_mem[w];
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [15:0] st;
        logic [7:0]  match;
        logic [1:0]  e_res;
        logic        e_err;
        logic        e_wb;
        logic        e_upd;
        logic [2:0]  e_way;
        logic [1:0]  e_st;
        int          d;
    } vec_t;

    typedef struct {
        logic [1:0] res;
        logic       err;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    vec_t vecs [12];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] st1(input int w, input logic [1:0] s);
        return 16'(s) << (2 * w);
    endfunction

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] addr,
                                input logic [15:0] st, input logic [7:0] match,
                                input logic [1:0] e_res, input logic e_err,
                                input logic e_wb, input logic e_upd,
                                input logic [2:0] e_way, input logic [1:0] e_st, input int d);
        vec_t v;
        v.op = op; v.addr = addr; v.st = st; v.match = match;
        v.e_res = e_res; v.e_err = e_err; v.e_wb = e_wb; v.e_upd = e_upd;
        v.e_way = e_way; v.e_st = e_st; v.d = d;
        return v;
    endfunction

    // Result checker: every res_valid pulse consumes one expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid) begin
                if (sb.size() == 0) begin
                    check("res_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("res", 32'(res), 32'(mon_e.res));
                    check("proto_err", 32'(proto_err), 32'(mon_e.err));
                end
            end else if (proto_err) begin
                check("proto_err_stray", 32'd1, 32'd0);
            end
        end
    end

    task automatic load_array(input vec_t v);
        for (int w = 0; w < WAYS; w++) begin
            st_mem[w]  = v.st[2*w +: 2];
            tag_mem[w] = v.match[w] ? v.addr[31:20] : (v.addr[31:20] ^ 12'h5A5);
        end
    endtask

    // Cycle 0 accept, cycle 1 lookup, cycle 2 result; returns at cycle 2 sample.
    task automatic accept(input logic [1:0] op, input logic [31:0] addr,
                          input logic [1:0] e_res, input logic e_err);
        exp_t e;
        e.res = e_res;
        e.err = e_err;
        sb.push_back(e);
        @(posedge clk); #1;
        snp_valid = 1'b1; snp_op = op; snp_addr = addr;
        @(negedge clk);
        check("ready_c0", 32'(snp_ready), 32'd1);
        @(posedge clk); #1;
        snp_valid = 1'b0; snp_op = ~op; snp_addr = ~addr;
        @(negedge clk);
        check("tl_req_c1", 32'(tl_req), 32'd1);
        check("tl_index_c1", 32'(tl_index), 32'(addr[19:6]));
        check("ready_c1", 32'(snp_ready), 32'd0);
        @(negedge clk);
        check("res_valid_c2", 32'(res_valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] line;
        int  k;
        bit  done;
        line = {v.addr[31:6], 6'b0};
        load_array(v);
        wb_ready = (v.d == 0);
        accept(v.op, v.addr, v.e_res, v.e_err);
        if (v.e_wb) begin
            k = 0;
            done = 0;
            while (!done) begin
                @(negedge clk);
                check("wb_valid", 32'(wb_valid), 32'd1);
                check("wb_addr", wb_addr, line);
                check("ready_wb", 32'(snp_ready), 32'd0);
                if (wb_ready) begin
                    done = 1;
                end else if (k > 40) begin
                    check("wb_timeout", 32'd0, 32'd1);
                    done = 1;
                end else begin
                    k++;
                    @(posedge clk); #1;
                    wb_ready = (k >= v.d);
                end
            end
            @(posedge clk); #1;
            wb_ready = 1'b0;
        end
        if (v.e_upd) begin
            @(negedge clk);
            check("su_we", 32'(su_we), 32'd1);
            check("su_index", 32'(su_index), 32'(v.addr[19:6]));
            check("su_way", 32'(su_way), 32'(v.e_way));
            check("su_state", 32'(su_state), 32'(v.e_st));
            check("wb_valid_upd", 32'(wb_valid), 32'd0);
            check("ready_upd", 32'(snp_ready), 32'd0);
        end
        @(negedge clk);
        check("ready_end", 32'(snp_ready), 32'd1);
        check("su_we_end", 32'(su_we), 32'd0);
        check("wb_valid_end", 32'(wb_valid), 32'd0);
    endtask

    initial begin
        vec_t        va;
        logic [31:0] addr_a, addr_b, line_r;

        rst_n = 1'b0; snp_valid = 1'b0; snp_op = 2'b00; snp_addr = '0; wb_ready = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            tag_mem[w] = '0;
            st_mem[w]  = ST_I;
        end

        vecs[0]  = mk(READ,  32'h1234_5640, st1(3, ST_M),                8'h08, HITM,  1'b0, 1'b1, 1'b1, 3'd3, ST_S, 0);
        vecs[1]  = mk(RFO,   32'h0ABC_D000, st1(0, ST_E),                8'h01, HIT,   1'b0, 1'b0, 1'b1, 3'd0, ST_I, 0);
        vecs[2]  = mk(INVAL, 32'h5555_0040, st1(2, ST_S) | st1(5, ST_I), 8'h24, HIT,   1'b0, 1'b0, 1'b1, 3'd2, ST_I, 0);
        vecs[3]  = mk(WRITE, 32'h0000_1FC0, st1(4, ST_S),                8'h10, HIT,   1'b1, 1'b0, 1'b0, 3'd0, ST_I, 0);
        vecs[4]  = mk(WRITE, 32'h0000_1FC0, 16'h5555,                    8'h00, NOHIT, 1'b0, 1'b0, 1'b0, 3'd0, ST_I, 0);
        vecs[5]  = mk(READ,  32'hFFFF_FFC0, st1(6, ST_E),                8'h40, HIT,   1'b0, 1'b0, 1'b1, 3'd6, ST_S, 0);
        vecs[6]  = mk(READ,  32'h8000_0000, st1(1, ST_S),                8'h02, HIT,   1'b0, 1'b0, 1'b0, 3'd0, ST_I, 0);
        vecs[7]  = mk(INVAL, 32'h2468_ACC0, st1(7, ST_M),                8'h80, HITM,  1'b1, 1'b1, 1'b1, 3'd7, ST_I, 2);
        vecs[8]  = mk(RFO,   32'h1357_9BC0, st1(0, ST_I) | st1(1, ST_M), 8'h03, HITM,  1'b0, 1'b1, 1'b1, 3'd1, ST_I, 1);
        vecs[9]  = mk(READ,  32'h0F0F_0F00, st1(0, ST_S) | st1(4, ST_M), 8'h11, HIT,   1'b0, 1'b0, 1'b0, 3'd0, ST_I, 0);
        vecs[10] = mk(RFO,   32'h7777_7740, st1(5, ST_S) | st1(2, ST_E), 8'h20, HIT,   1'b0, 1'b0, 1'b1, 3'd5, ST_I, 0);
        vecs[11] = mk(RFO,   32'h3C3C_3C00, 16'h0000,                    8'hFF, NOHIT, 1'b0, 1'b0, 1'b0, 3'd0, ST_I, 0);

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(snp_ready), 32'd1);
        check("rst_tl_req", 32'(tl_req), 32'd0);
        check("rst_su_we", 32'(su_we), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_wb_addr", wb_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Back-to-back: snp_valid stays high; the second op is taken at cycle 3.
        addr_a = 32'h4444_4440;
        addr_b = 32'h9999_9980;
        va = mk(READ, addr_a, st1(1, ST_S), 8'h02, HIT, 1'b0, 1'b0, 1'b0, 3'd0, ST_I, 0);
        load_array(va);
        sb.push_back('{HIT, 1'b0});
        sb.push_back('{NOHIT, 1'b0});
        @(posedge clk); #1;
        snp_valid = 1'b1; snp_op = READ; snp_addr = addr_a;
        @(negedge clk);
        check("b2b_ready_c0", 32'(snp_ready), 32'd1);
        @(posedge clk); #1;
        snp_op = WRITE; snp_addr = addr_b;
        @(negedge clk);
        check("b2b_tl_req_c1", 32'(tl_req), 32'd1);
        check("b2b_tl_index_c1", 32'(tl_index), 32'(addr_a[19:6]));
        check("b2b_ready_c1", 32'(snp_ready), 32'd0);
        @(negedge clk);
        check("b2b_res_valid_c2", 32'(res_valid), 32'd1);
        check("b2b_ready_c2", 32'(snp_ready), 32'd0);
        @(negedge clk);
        check("b2b_ready_c3", 32'(snp_ready), 32'd1);
        @(posedge clk); #1;
        snp_valid = 1'b0;
        @(negedge clk);
        check("b2b_tl_req_c4", 32'(tl_req), 32'd1);
        check("b2b_tl_index_c4", 32'(tl_index), 32'(addr_b[19:6]));
        @(negedge clk);
        check("b2b_res_valid_c5", 32'(res_valid), 32'd1);
        @(negedge clk);
        check("b2b_ready_c6", 32'(snp_ready), 32'd1);

        // Writeback stall followed by reset in the middle of WB.
        va = mk(READ, 32'h0BAD_0FC0, st1(3, ST_M), 8'h08, HITM, 1'b0, 1'b1, 1'b1, 3'd3, ST_S, 0);
        line_r = 32'h0BAD_0FC0;
        load_array(va);
        wb_ready = 1'b0;
        accept(READ, 32'h0BAD_0FC0, HITM, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_wb_valid", 32'(wb_valid), 32'd1);
            check("stall_wb_addr", wb_addr, line_r);
            check("stall_ready", 32'(snp_ready), 32'd0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wb_valid", 32'(wb_valid), 32'd0);
        check("arst_wb_addr", wb_addr, 32'd0);
        check("arst_su_we", 32'(su_we), 32'd0);
        check("arst_su_state", 32'(su_state), 32'd0);
        check("arst_tl_req", 32'(tl_req), 32'd0);
        check("arst_res_valid", 32'(res_valid), 32'd0);
        check("arst_ready", 32'(snp_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wb_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_su_we", 32'(su_we), 32'd0);
            check("post_rst_wb_valid", 32'(wb_valid), 32'd0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
